// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the sipo_rx serial frame receiver.
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam int   DATA_W    = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit serial-in shift register; LSB_FIRST places the first bit shifted in at dout[0].
// One bit enters per shift_en edge; the full word is valid after WIDTH shifts.
module sipo_shreg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            // Shifting toward bit 0 leaves the oldest bit in the LSB once the word is full.
            if (LSB_FIRST) begin
                sr_d = {din, sr_q[WIDTH-1:1]};
            end else begin
                sr_d = {sr_q[WIDTH-2:0], din};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q;

endmodule

// File: rtl/sipo_rx.sv
// Strobed start/data/stop frame receiver feeding a parallel-load register via pdata/load.
// pdata and load update on the stop-bit edge; define SIPO_RX_PARITY_EN to add an even-parity bit.
import sipo_rx_pkg::*;

module sipo_rx #(
    parameter int WIDTH     = DATA_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin_valid,
    input  logic             sin,
    output logic [WIDTH-1:0] pdata,
    output logic             load,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             load_q, load_d;
    logic             ferr_q, ferr_d;
    logic             par_err_q, par_err_d;
    logic [WIDTH-1:0] sr_word;
    logic             shift_en;

    assign shift_en = sin_valid && (state_q == DATA);

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .rst      (reset),
        .shift_en (shift_en),
        .din      (sin),
        .dout     (sr_word)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pdata_d   = pdata_q;
        load_d    = 1'b0;
        ferr_d    = 1'b0;
        par_err_d = par_err_q;
        if (sin_valid) begin
            case (state_q)
                IDLE: begin
                    if (sin == START_BIT) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        par_err_d = 1'b0;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef SIPO_RX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef SIPO_RX_PARITY_EN
                PAR: begin
                    // Even parity: data ones plus the parity bit must total an even count.
                    par_err_d = (sin != ^sr_word);
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    // A low stop bit is only an error; it never doubles as a start bit.
                    if ((sin == STOP_BIT) && !par_err_q) begin
                        pdata_d = sr_word;
                        load_d  = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pdata_q   <= '0;
            load_q    <= 1'b0;
            ferr_q    <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pdata_q   <= pdata_d;
            load_q    <= load_d;
            ferr_q    <= ferr_d;
            par_err_q <= par_err_d;
        end
    end

    assign pdata     = pdata_q;
    assign load      = load_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule
